// File: rtl/if_fetch_redirect.sv
// IF-stage PC and fetch controller: issues I-cache reads, buffers one
// fetched instruction across stalls, and redirects on EX branches.
module if_fetch_redirect #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          SQ_CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                branch_enable,
  input  logic [15:0]         br_addr,
  input  logic                stall,
  input  logic                icache_resp,
  input  logic [15:0]         icache_rdata,
  output logic                icache_read,
  output logic [15:0]         icache_addr,
  output logic                if_valid,
  output logic [15:0]         if_pc,
  output logic [15:0]         if_instr,
  output logic                flush,
  output logic [SQ_CNT_W-1:0] squash_count
);

  localparam logic [15:0] RST_PC = {RESET_PC[15:1], 1'b0};

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DRAIN
  } state_t;

  state_t      state, state_nx;
  logic [15:0] pc, pc_nx;
  logic [15:0] redir_pc, redir_nx;
  logic [15:0] hold_pc, hold_instr;
  logic [15:0] tgt;
  logic        sq_sat;

  assign tgt    = {br_addr[15:1], 1'b0};
  assign flush  = branch_enable;
  assign sq_sat = (squash_count == {SQ_CNT_W{1'b1}});

  // Gated by rst_n so no request leaks out while the I-cache is in reset.
  assign icache_read = rst_n & (state == FETCH || state == DRAIN);
  assign icache_addr = pc;

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    redir_nx = redir_pc;
    unique case (state)
      FETCH: begin
        if (branch_enable) begin
          if (icache_resp) begin
            pc_nx = tgt;
          end else begin
            redir_nx = tgt;
            state_nx = DRAIN;
          end
        end else if (icache_resp) begin
          if (stall) state_nx = HOLD;
          else       pc_nx    = pc + 16'd2;
        end
      end
      HOLD: begin
        if (branch_enable) begin
          pc_nx    = tgt;
          state_nx = FETCH;
        end else if (!stall) begin
          pc_nx    = pc + 16'd2;
          state_nx = FETCH;
        end
      end
      DRAIN: begin
        // The old read must complete; the newest target is the one used.
        if (icache_resp) begin
          pc_nx    = branch_enable ? tgt : redir_pc;
          state_nx = FETCH;
        end else if (branch_enable) begin
          redir_nx = tgt;
        end
      end
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= RST_PC;
      redir_pc <= 16'h0000;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      redir_pc <= redir_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid   <= 1'b0;
      if_pc      <= 16'h0000;
      if_instr   <= 16'h0000;
      hold_pc    <= 16'h0000;
      hold_instr <= 16'h0000;
    end else if (branch_enable) begin
      if_valid   <= 1'b0;
      hold_pc    <= 16'h0000;
      hold_instr <= 16'h0000;
    end else if (!stall) begin
      if (state == FETCH && icache_resp) begin
        if_valid <= 1'b1;
        if_pc    <= pc;
        if_instr <= icache_rdata;
      end else if (state == HOLD) begin
        if_valid <= 1'b1;
        if_pc    <= hold_pc;
        if_instr <= hold_instr;
      end else begin
        if_valid <= 1'b0;
      end
    end else if (state == FETCH && icache_resp) begin
      hold_pc    <= pc;
      hold_instr <= icache_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      squash_count <= '0;
    end else if (branch_enable && !sq_sat) begin
      squash_count <= squash_count + SQ_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_if_fetch_redirect.sv
// Directed bench for if_fetch_redirect: fetch, stall/hold, redirect,
// drain, wrap, async reset and squash counter saturation.
module tb_if_fetch_redirect;

  logic        clk;
  logic        rst_n;
  logic        branch_enable;
  logic [15:0] br_addr;
  logic        stall;
  logic        icache_resp;
  logic [15:0] icache_rdata;
  logic        icache_read;
  logic [15:0] icache_addr;
  logic        if_valid;
  logic [15:0] if_pc;
  logic [15:0] if_instr;
  logic        flush;
  logic [7:0]  squash_count;

  int n_tests = 0;
  int n_fail  = 0;

  if_fetch_redirect #(
    .RESET_PC(16'h0000),
    .SQ_CNT_W(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .branch_enable(branch_enable),
    .br_addr      (br_addr),
    .stall        (stall),
    .icache_resp  (icache_resp),
    .icache_rdata (icache_rdata),
    .icache_read  (icache_read),
    .icache_addr  (icache_addr),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .flush        (flush),
    .squash_count (squash_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    branch_enable = 1'b0;
    br_addr       = 16'h0000;
    stall         = 1'b0;
    icache_resp   = 1'b1;
    icache_rdata  = 16'hFFFF;
    tick();
    tick();
    check("rst_read",  icache_read, 0);
    check("rst_valid", if_valid, 0);
    check("rst_pc",    if_pc, 16'h0000);
    check("rst_instr", if_instr, 16'h0000);
    check("rst_sq",    squash_count, 0);
    icache_resp = 1'b0;
    rst_n = 1'b1;
    #1;
    check("t1_read0", icache_read, 1);
    check("t1_addr0", icache_addr, 16'h0000);

    // 1: resp every second cycle
    tick();
    check("t1_novalid", if_valid, 0);
    for (int i = 0; i < 3; i++) begin
      icache_resp  = 1'b1;
      icache_rdata = 16'hA000 + 16'(2 * i);
      tick();
      icache_resp = 1'b0;
      check("t1_valid", if_valid, 1);
      check("t1_pc",    if_pc, 16'(2 * i));
      check("t1_instr", if_instr, 16'hA000 + 16'(2 * i));
      check("t1_addr",  icache_addr, 16'(2 * i + 2));
      tick();
      check("t1_gap", if_valid, 0);
    end
    for (int i = 0; i < 5; i++) begin
      icache_resp  = 1'b1;
      icache_rdata = 16'hA006 + 16'(2 * i);
      tick();
    end
    icache_resp = 1'b0;
    check("t1_pcE",   if_pc, 16'h000E);
    check("t1_addr10", icache_addr, 16'h0010);

    // 2: stall across a resp
    stall        = 1'b1;
    icache_resp  = 1'b1;
    icache_rdata = 16'hB010;
    tick();
    icache_resp = 1'b0;
    check("t2_read",   icache_read, 0);
    check("t2_keepv",  if_valid, 1);
    check("t2_keeppc", if_pc, 16'h000E);
    for (int i = 0; i < 4; i++) tick();
    check("t2_read4", icache_read, 0);
    stall = 1'b0;
    tick();
    check("t2_valid", if_valid, 1);
    check("t2_pc",    if_pc, 16'h0010);
    check("t2_instr", if_instr, 16'hB010);
    check("t2_addr",  icache_addr, 16'h0012);
    check("t2_rd",    icache_read, 1);
    tick();
    check("t2_once", if_valid, 0);

    // 3: redirect while a read to 0020 is outstanding
    for (int i = 0; i < 7; i++) begin
      icache_resp  = 1'b1;
      icache_rdata = 16'h1000;
      tick();
    end
    icache_resp = 1'b0;
    tick();
    check("t3_addr20", icache_addr, 16'h0020);
    branch_enable = 1'b1;
    br_addr       = 16'h3001;
    #1;
    check("t3_flush", flush, 1);
    tick();
    branch_enable = 1'b0;
    #1;
    check("t3_flush0", flush, 0);
    check("t3_drain_rd", icache_read, 1);
    check("t3_drain_ad", icache_addr, 16'h0020);
    check("t3_sq", squash_count, 1);
    tick();
    tick();
    icache_resp  = 1'b1;
    icache_rdata = 16'hDEAD;
    tick();
    icache_resp = 1'b0;
    check("t3_drop", if_valid, 0);
    check("t3_addr", icache_addr, 16'h3000);

    // 4: branch together with resp
    icache_resp   = 1'b1;
    icache_rdata  = 16'hC000;
    branch_enable = 1'b1;
    br_addr       = 16'h4000;
    tick();
    icache_resp   = 1'b0;
    branch_enable = 1'b0;
    check("t4_valid", if_valid, 0);
    check("t4_addr",  icache_addr, 16'h4000);
    check("t4_sq",    squash_count, 2);

    // 5: two redirects during DRAIN, then pc wrap
    branch_enable = 1'b1;
    br_addr       = 16'h5000;
    tick();
    branch_enable = 1'b0;
    tick();
    branch_enable = 1'b1;
    br_addr       = 16'h6000;
    tick();
    branch_enable = 1'b0;
    check("t5_sq",   squash_count, 4);
    check("t5_old",  icache_addr, 16'h4000);
    icache_resp = 1'b1;
    tick();
    icache_resp = 1'b0;
    check("t5_addr",  icache_addr, 16'h6000);
    check("t5_valid", if_valid, 0);
    icache_resp   = 1'b1;
    branch_enable = 1'b1;
    br_addr       = 16'hFFFF;
    tick();
    branch_enable = 1'b0;
    check("t5_fffe", icache_addr, 16'hFFFE);
    icache_rdata = 16'hE000;
    tick();
    icache_resp = 1'b0;
    check("t5_wpc",  if_pc, 16'hFFFE);
    check("t5_wrap", icache_addr, 16'h0000);

    // 6: reset mid-DRAIN, then mid-HOLD
    branch_enable = 1'b1;
    br_addr       = 16'h7000;
    tick();
    branch_enable = 1'b0;
    check("t6_sq", squash_count, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rd",    icache_read, 0);
    check("t6_valid", if_valid, 0);
    check("t6_sq0",   squash_count, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("t6_raddr", icache_addr, 16'h0000);
    check("t6_rread", icache_read, 1);
    icache_resp  = 1'b1;
    icache_rdata = 16'h5555;
    tick();
    check("t6_v1", if_valid, 1);
    stall = 1'b1;
    tick();
    icache_resp = 1'b0;
    check("t6_hold", icache_read, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_hvalid", if_valid, 0);
    check("t6_hpc",    if_pc, 16'h0000);
    tick();
    stall = 1'b0;
    rst_n = 1'b1;
    #1;
    check("t6_haddr", icache_addr, 16'h0000);
    check("t6_hread", icache_read, 1);

    // squash counter saturation
    branch_enable = 1'b1;
    br_addr       = 16'h8000;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 100) check("sat_100", squash_count, 8'd100);
      if (i == 255) check("sat_255", squash_count, 8'hFF);
    end
    branch_enable = 1'b0;
    check("sat_300", squash_count, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
